pipe_hazard_ctrl: RTL and testbench

- Central stall/flush scheduler for the 5-stage pipeline (PC, IF/ID, ID/EX, EX/MEM, MEM/WB segment registers).
- Generates per-segment stall and refresh controls from three sources:
  - load-use hazards
  - the multi-cycle mult/div unit occupancy
  - data-memory wait
- Also handles exception/eret flushes.
- Owns the MDU occupancy FSM and the pending-flush latch.
- Never drives stall and refresh to the same segment in one cycle, because refresh overrides stall in every segment register.

---
 rtl/pipe_hazard_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush scheduler for the 5-stage pipeline.
// Combines load-use, MDU occupancy, data-memory wait and exception flush
// into per-segment stall/refresh controls. Owns the MDU occupancy FSM and
// the pending-flush latch.
// Optional macro PIPE_HAZARD_PERF_EN adds saturating stall/flush counters.
//
// Handshake note: data_data_ok qualifies an outstanding mem_data_req; a
// cycle with mem_data_req=1 and data_data_ok=0 is a wait cycle, and the
// cycle where both are 1 completes the access and releases the pipeline.
module pipe_hazard_ctrl #(
   parameter int MULT_LAT = 2,
   parameter int DIV_LAT  = 33,
   parameter int CNT_W    = 6
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             id_rs_ren,
   input  logic             id_rt_ren,
   input  logic [4:0]       id_rs,
   input  logic [4:0]       id_rt,
   input  logic             ex_regwen,
   input  logic [4:0]       ex_wreg,
   input  logic             ex_load,
   input  logic             ex_cp0ren,
   input  logic             ex_mult,
   input  logic             ex_div,
   input  logic             mem_data_req,
   input  logic             data_data_ok,
   input  logic             exc_flush,
   output logic             pc_stall,
   output logic             if_id_stall,
   output logic             id_ex_stall,
   output logic             ex_mem_stall,
   output logic             mem_wb_stall,
   output logic             if_id_refresh,
   output logic             id_ex_refresh,
   output logic             ex_mem_refresh,
   output logic             mdu_busy,
   output logic [1:0]       md_state_dbg,
   output logic [CNT_W-1:0] md_count_dbg
`ifdef PIPE_HAZARD_PERF_EN
   ,
   output logic [31:0]      perf_stall_cnt,
   output logic [15:0]      perf_flush_cnt
`endif
);

   typedef enum logic [1:0] {
      MD_IDLE = 2'd0,
      MD_RUN  = 2'd1,
      MD_DONE = 2'd2
   } md_state_t;

   localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_LAT - 1);
   localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_LAT - 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_ZERO  = '0;

   md_state_t        md_state, md_state_nxt;
   logic [CNT_W-1:0] md_count, md_count_nxt;
   logic             flush_pend, flush_pend_nxt;

   logic             mem_wait;
   logic             flush_now;
   logic             md_req;
   logic             md_hold;
   logic             lu;
   logic [CNT_W-1:0] md_load;

   assign mem_wait  = mem_data_req & ~data_data_ok;
   assign flush_now = (exc_flush | flush_pend) & ~mem_wait;
   assign md_req    = ex_mult | ex_div;
   // The DONE cycle releases EX so the MDU op advances and cannot restart.
   assign md_hold   = md_req & (md_state != MD_DONE);
   assign md_load   = ex_div ? DIV_LOAD : MULT_LOAD;
   assign lu        = ex_regwen & (ex_load | ex_cp0ren) & (ex_wreg != 5'd0) &
                      ((id_rs_ren & (id_rs == ex_wreg)) |
                       (id_rt_ren & (id_rt == ex_wreg)));

   assign md_state_dbg = md_state;
   assign md_count_dbg = md_count;

   // State register for the MDU FSM and the pending-flush latch.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         md_state   <= MD_IDLE;
         md_count   <= CNT_ZERO;
         flush_pend <= 1'b0;
      end else begin
         md_state   <= md_state_nxt;
         md_count   <= md_count_nxt;
         flush_pend <= flush_pend_nxt;
      end
   end

   // Next-state logic: a flush aborts the MDU; a flush seen during a
   // memory wait is parked until the wait ends.
   always_comb begin
      md_state_nxt   = md_state;
      md_count_nxt   = md_count;
      flush_pend_nxt = flush_pend;

      if (flush_now) begin
         flush_pend_nxt = 1'b0;
      end else if (exc_flush && mem_wait) begin
         flush_pend_nxt = 1'b1;
      end

      if (flush_now) begin
         md_state_nxt = MD_IDLE;
         md_count_nxt = CNT_ZERO;
      end else begin
         case (md_state)
            MD_IDLE: begin
               if (md_req && !mem_wait) begin
                  if (md_load == CNT_ZERO) begin
                     md_state_nxt = MD_DONE;
                     md_count_nxt = CNT_ZERO;
                  end else begin
                     md_state_nxt = MD_RUN;
                     md_count_nxt = md_load;
                  end
               end
            end
            MD_RUN: begin
               if (md_count <= CNT_ONE) begin
                  md_state_nxt = MD_DONE;
                  md_count_nxt = CNT_ZERO;
               end else begin
                  md_count_nxt = md_count - CNT_ONE;
               end
            end
            MD_DONE: begin
               md_state_nxt = MD_IDLE;
               md_count_nxt = CNT_ZERO;
            end
            default: begin
               md_state_nxt = MD_IDLE;
               md_count_nxt = CNT_ZERO;
            end
         endcase
      end
   end

   // Output priority: flush > mem wait > MDU hold > load-use. Outputs are
   // forced low while reset is held, independent of the other inputs.
   always_comb begin
      pc_stall       = 1'b0;
      if_id_stall    = 1'b0;
      id_ex_stall    = 1'b0;
      ex_mem_stall   = 1'b0;
      mem_wb_stall   = 1'b0;
      if_id_refresh  = 1'b0;
      id_ex_refresh  = 1'b0;
      ex_mem_refresh = 1'b0;
      mdu_busy       = 1'b0;
      if (resetn) begin
         mdu_busy = (md_state != MD_IDLE);
         if (flush_now) begin
            if_id_refresh  = 1'b1;
            id_ex_refresh  = 1'b1;
            ex_mem_refresh = 1'b1;
         end else if (mem_wait) begin
            pc_stall     = 1'b1;
            if_id_stall  = 1'b1;
            id_ex_stall  = 1'b1;
            ex_mem_stall = 1'b1;
            mem_wb_stall = 1'b1;
         end else if (md_hold) begin
            pc_stall       = 1'b1;
            if_id_stall    = 1'b1;
            id_ex_stall    = 1'b1;
            ex_mem_refresh = 1'b1;
         end else if (lu) begin
            pc_stall      = 1'b1;
            if_id_stall   = 1'b1;
            id_ex_refresh = 1'b1;
         end
      end
   end

`ifdef PIPE_HAZARD_PERF_EN
   // Saturating counters of PC-stall cycles and flushes.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         perf_stall_cnt <= '0;
         perf_flush_cnt <= '0;
      end else begin
         if (pc_stall && (perf_stall_cnt != '1)) begin
            perf_stall_cnt <= perf_stall_cnt + 32'd1;
         end
         if (flush_now && (perf_flush_cnt != '1)) begin
            perf_flush_cnt <= perf_flush_cnt + 16'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed scenarios plus randomized traffic, checked
// against a cycle-count reference model through an expected-value queue.
module tb_pipe_hazard_ctrl;

   localparam int MULT_LAT = 2;
   localparam int DIV_LAT  = 33;
   localparam int CNT_W    = 6;
   localparam int W        = 9;

   typedef struct packed {
      logic       resetn;
      logic       rs_ren;
      logic       rt_ren;
      logic [4:0] rs;
      logic [4:0] rt;
      logic       regwen;
      logic [4:0] wreg;
      logic       load;
      logic       cp0ren;
      logic       mult;
      logic       div;
      logic       mem_req;
      logic       data_ok;
      logic       exc;
   } stim_t;

   // ---------------- clock / reset / DUT ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       resetn;
   logic       id_rs_ren, id_rt_ren;
   logic [4:0] id_rs, id_rt;
   logic       ex_regwen;
   logic [4:0] ex_wreg;
   logic       ex_load, ex_cp0ren, ex_mult, ex_div;
   logic       mem_data_req, data_data_ok, exc_flush;
   logic       pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, mem_wb_stall;
   logic       if_id_refresh, id_ex_refresh, ex_mem_refresh, mdu_busy;
   logic [1:0] md_state_dbg;
   logic [CNT_W-1:0] md_count_dbg;
`ifdef PIPE_HAZARD_PERF_EN
   logic [31:0] perf_stall_cnt;
   logic [15:0] perf_flush_cnt;
`endif

   pipe_hazard_ctrl #(
      .MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .resetn(resetn),
      .id_rs_ren(id_rs_ren), .id_rt_ren(id_rt_ren),
      .id_rs(id_rs), .id_rt(id_rt),
      .ex_regwen(ex_regwen), .ex_wreg(ex_wreg),
      .ex_load(ex_load), .ex_cp0ren(ex_cp0ren),
      .ex_mult(ex_mult), .ex_div(ex_div),
      .mem_data_req(mem_data_req), .data_data_ok(data_data_ok),
      .exc_flush(exc_flush),
      .pc_stall(pc_stall), .if_id_stall(if_id_stall),
      .id_ex_stall(id_ex_stall), .ex_mem_stall(ex_mem_stall),
      .mem_wb_stall(mem_wb_stall),
      .if_id_refresh(if_id_refresh), .id_ex_refresh(id_ex_refresh),
      .ex_mem_refresh(ex_mem_refresh), .mdu_busy(mdu_busy),
      .md_state_dbg(md_state_dbg), .md_count_dbg(md_count_dbg)
`ifdef PIPE_HAZARD_PERF_EN
      , .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
`endif
   );

   logic [W-1:0] got;
   assign got = {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, mem_wb_stall,
                 if_id_refresh, id_ex_refresh, ex_mem_refresh, mdu_busy};

   // ---------------- reference model ----------------
   // MDU tracked as "cycles since the op was accepted": the op is held
   // until LAT cycles have elapsed, that cycle is the release cycle.
   bit m_active;
   int m_elapsed;
   int m_lat;
   bit m_pend;

   function automatic logic [W-1:0] model_out(input stim_t s);
      logic mw, fn, hold, lu, rel;
      logic [W-1:0] v;
      v = '0;
      if (!s.resetn) return v;
      mw   = s.mem_req & ~s.data_ok;
      fn   = (s.exc | m_pend) & ~mw;
      rel  = m_active && (m_elapsed == m_lat);
      hold = (s.mult | s.div) & ~rel;
      lu   = s.regwen & (s.load | s.cp0ren) & (s.wreg != 0) &
             ((s.rs_ren & (s.rs == s.wreg)) | (s.rt_ren & (s.rt == s.wreg)));
      v[0] = m_active;
      if (fn)        v[3:1] = 3'b111;
      else if (mw)   v[8:4] = 5'b11111;
      else if (hold) begin v[8:6] = 3'b111; v[1] = 1'b1; end
      else if (lu)   begin v[8:7] = 2'b11; v[2] = 1'b1; end
      return v;
   endfunction

   task automatic model_advance(input stim_t p);
      logic mw, fn;
      if (!p.resetn) begin
         m_active = 0; m_elapsed = 0; m_lat = 0; m_pend = 0;
         return;
      end
      mw = p.mem_req & ~p.data_ok;
      fn = (p.exc | m_pend) & ~mw;
      if (fn)                m_pend = 0;
      else if (p.exc && mw)  m_pend = 1;
      if (fn) begin
         m_active = 0;
      end else if (!m_active) begin
         if ((p.mult | p.div) && !mw) begin
            m_active  = 1;
            m_lat     = p.div ? DIV_LAT : MULT_LAT;
            m_elapsed = 1;
         end
      end else if (m_elapsed == m_lat) begin
         m_active = 0;
      end else begin
         m_elapsed++;
      end
   endtask

   // ---------------- driver ----------------
   logic [W-1:0] exp_q[$];
   stim_t        cur;
   logic [W-1:0] last_exp;
   int           tests  = 0;
   int           fails  = 0;
   int           cycle  = 0;

   task automatic apply(input stim_t s);
      resetn       = s.resetn;
      id_rs_ren    = s.rs_ren;  id_rt_ren = s.rt_ren;
      id_rs        = s.rs;      id_rt     = s.rt;
      ex_regwen    = s.regwen;  ex_wreg   = s.wreg;
      ex_load      = s.load;    ex_cp0ren = s.cp0ren;
      ex_mult      = s.mult;    ex_div    = s.div;
      mem_data_req = s.mem_req; data_data_ok = s.data_ok;
      exc_flush    = s.exc;
   endtask

   task automatic step(input stim_t s);
      @(posedge clk);
      model_advance(cur);
      #1;
      apply(s);
      cur      = s;
      last_exp = model_out(s);
      exp_q.push_back(last_exp);
   endtask

   function automatic stim_t quiet();
      stim_t s;
      s = '0;
      s.resetn = 1'b1;
      return s;
   endfunction

   // ---------------- monitor / scoreboard ----------------
   always @(negedge clk) begin
      cycle++;
      if (exp_q.size() != 0) begin
         logic [W-1:0] e;
         e = exp_q.pop_front();
         tests++;
         if (got !== e) begin
            fails++;
            $display("FAIL outputs cycle %0d got %b exp %b (pc,ifid,idex,exmem,memwb stall | ifid,idex,exmem refresh | busy)",
                     cycle, got, e);
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      stim_t s;
      cur = '0;
      apply(cur);

      // reset held with noisy inputs: everything must stay low
      for (int i = 0; i < 3; i++) begin
         s = stim_t'($urandom());
         s.resetn = 1'b0;
         step(s);
      end

      // load-use: LW r5 in EX, ADDU reading r5 in ID
      s = quiet(); s.regwen = 1; s.load = 1; s.wreg = 5; s.rs_ren = 1; s.rs = 5; s.rt = 1;
      step(s);
      s.regwen = 0; s.load = 0;
      step(s);
      // same with destination r0: no stall
      s = quiet(); s.regwen = 1; s.load = 1; s.wreg = 0; s.rs_ren = 1; s.rs = 0;
      step(s);
      // MFC0 behaves like a load, via rt
      s = quiet(); s.regwen = 1; s.cp0ren = 1; s.wreg = 7; s.rt_ren = 1; s.rt = 7;
      step(s);

      // DIV: held 33 cycles, release cycle, then idle
      s = quiet(); s.div = 1;
      for (int i = 0; i < DIV_LAT + 1; i++) step(s);
      step(quiet());
      step(quiet());

      // MULT run
      s = quiet(); s.mult = 1;
      for (int i = 0; i < MULT_LAT + 1; i++) step(s);
      step(quiet());

      // memory wait for 4 cycles, released on data_ok
      s = quiet(); s.mem_req = 1;
      for (int i = 0; i < 4; i++) step(s);
      s.data_ok = 1;
      step(s);
      step(quiet());

      // exception during a 3-cycle memory wait
      s = quiet(); s.mem_req = 1; s.exc = 1;
      step(s);
      s.exc = 0;
      step(s);
      step(s);
      s.data_ok = 1;
      step(s);
      step(quiet());
      step(quiet());

      // exception while DIV counts down at 10
      s = quiet(); s.div = 1;
      for (int i = 0; i < 23; i++) step(s);
      s.exc = 1;
      step(s);
      step(quiet());
      step(quiet());

      // reset dropped mid-DIV
      s = quiet(); s.div = 1;
      for (int i = 0; i < 29; i++) step(s);
      s.resetn = 0;
      step(s);
      step(quiet());
      step(quiet());

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         stim_t p;
         p = cur;
         s = quiet();
         s.resetn  = ($urandom_range(0, 499) != 0);
         s.rs_ren  = $urandom_range(0, 1);
         s.rt_ren  = $urandom_range(0, 1);
         s.rs      = 5'($urandom_range(0, 3));
         s.rt      = 5'($urandom_range(0, 3));
         s.regwen  = $urandom_range(0, 1);
         s.wreg    = 5'($urandom_range(0, 3));
         s.load    = ($urandom_range(0, 2) == 0);
         s.cp0ren  = ($urandom_range(0, 7) == 0);
         if (last_exp[1] || last_exp[5]) begin
            s.mult = p.mult;
            s.div  = p.div;
         end else begin
            case ($urandom_range(0, 9))
               0: s.mult = 1'b1;
               1: s.div  = 1'b1;
               default: ;
            endcase
         end
         s.mem_req = ($urandom_range(0, 2) == 0);
         s.data_ok = $urandom_range(0, 1);
         s.exc     = ($urandom_range(0, 49) == 0);
         step(s);
      end
      step(quiet());

      @(negedge clk);
      @(posedge clk);
      tests++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL drain got %0d pending exp 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
